// File: rtl/seq_detect_ctrl_if.sv
// Event handshake bundle between the pattern-search controller and its consumer.
interface seq_detect_ctrl_if #(
  parameter int TMO_W = 16
);
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [TMO_W-1:0] evt_pos;

  modport master (output evt_valid, evt_code, evt_pos, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_pos, output evt_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-control wrapper around a maskable serial pattern matcher: arms on start,
// counts bits, enforces a bit-count timeout and reports MATCH/TIMEOUT/ABORT events.
module seq_detect_ctrl #(
  parameter int LEN   = 9,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data,
  input  logic                 data_vld,
  input  logic [LEN-1:0]       cfg_pattern,
  input  logic [LEN-1:0]       cfg_mask,
  input  logic                 cfg_oneshot,
  input  logic [TMO_W-1:0]     cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 evt_ovf,
  seq_detect_ctrl_if.master    evt
);

  localparam logic [1:0] CODE_MATCH   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_ABORT   = 2'b11;

  typedef enum logic [1:0] {IDLE, FILL, HUNT, REPORT} state_t;

  state_t           state_reg, state_next;
  logic [LEN-1:0]   shreg_reg, shreg_next;
  logic [LEN-1:0]   pattern_reg, pattern_next;
  logic [LEN-1:0]   mask_reg, mask_next;
  logic             oneshot_reg, oneshot_next;
  logic [TMO_W-1:0] timeout_reg, timeout_next;
  logic [TMO_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic             ovf_reg, ovf_next;
  logic             abort_pend_reg, abort_pend_next;
  logic [1:0]       code_reg, code_next;
  logic [TMO_W-1:0] pos_reg, pos_next;

  logic             accept;
  logic [LEN-1:0]   shreg_shift;
  logic [TMO_W-1:0] bit_cnt_inc;
  logic [TMO_W-1:0] tmo_cnt_inc;
  logic [CNT_W-1:0] match_cnt_inc;
  logic             filled;
  logic             hit;
  logic             tmo_hit;
  logic             handshake;
  logic             terminate;

  always_comb begin
    accept        = data_vld && (state_reg != IDLE);
    shreg_shift   = {shreg_reg[LEN-2:0], data};
    bit_cnt_inc   = (&bit_cnt_reg) ? bit_cnt_reg : bit_cnt_reg + TMO_W'(1);
    tmo_cnt_inc   = (&tmo_cnt_reg) ? tmo_cnt_reg : tmo_cnt_reg + TMO_W'(1);
    match_cnt_inc = (&match_cnt_reg) ? match_cnt_reg : match_cnt_reg + CNT_W'(1);
    // The shift register is full once the current bit is the LEN-th accepted one.
    filled        = (state_reg != FILL) || (bit_cnt_reg >= TMO_W'(LEN - 1));
    hit           = accept && filled && (((shreg_shift ^ pattern_reg) & mask_reg) == '0);
    tmo_hit       = accept && (timeout_reg != '0) && (tmo_cnt_inc >= timeout_reg);
    handshake     = (state_reg == REPORT) && evt.evt_ready;
    terminate     = oneshot_reg || (code_reg != CODE_MATCH) || abort_pend_reg || abort;
  end

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    pattern_next    = pattern_reg;
    mask_next       = mask_reg;
    oneshot_next    = oneshot_reg;
    timeout_next    = timeout_reg;
    bit_cnt_next    = bit_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    match_cnt_next  = match_cnt_reg;
    ovf_next        = ovf_reg;
    abort_pend_next = abort_pend_reg;
    code_next       = code_reg;
    pos_next        = pos_reg;

    if (accept) begin
      shreg_next   = shreg_shift;
      bit_cnt_next = bit_cnt_inc;
      tmo_cnt_next = hit ? '0 : tmo_cnt_inc;
    end

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next      = FILL;
          pattern_next    = cfg_pattern;
          mask_next       = cfg_mask;
          oneshot_next    = cfg_oneshot;
          timeout_next    = cfg_timeout;
          shreg_next      = '0;
          bit_cnt_next    = '0;
          tmo_cnt_next    = '0;
          match_cnt_next  = '0;
          ovf_next        = 1'b0;
          abort_pend_next = 1'b0;
        end
      end
      FILL, HUNT: begin
        if ((state_reg == FILL) && accept && (bit_cnt_inc >= TMO_W'(LEN)))
          state_next = HUNT;
        if (abort) begin
          state_next = REPORT;
          code_next  = CODE_ABORT;
          pos_next   = bit_cnt_reg;
        end else if (hit) begin
          state_next     = REPORT;
          code_next      = CODE_MATCH;
          pos_next       = bit_cnt_inc;
          match_cnt_next = match_cnt_inc;
        end else if (tmo_hit) begin
          state_next = REPORT;
          code_next  = CODE_TIMEOUT;
          pos_next   = bit_cnt_inc;
        end
      end
      REPORT: begin
        if (abort)
          abort_pend_next = 1'b1;
        if (hit)
          match_cnt_next = match_cnt_inc;
        if (handshake) begin
          abort_pend_next = 1'b0;
          if (terminate) begin
            state_next = IDLE;
          end else if (hit) begin
            code_next = CODE_MATCH;
            pos_next  = bit_cnt_inc;
          end else begin
            state_next = HUNT;
          end
        end else if (hit) begin
          ovf_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      pattern_reg    <= '0;
      mask_reg       <= '0;
      oneshot_reg    <= 1'b0;
      timeout_reg    <= '0;
      bit_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      match_cnt_reg  <= '0;
      ovf_reg        <= 1'b0;
      abort_pend_reg <= 1'b0;
      code_reg       <= '0;
      pos_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      pattern_reg    <= pattern_next;
      mask_reg       <= mask_next;
      oneshot_reg    <= oneshot_next;
      timeout_reg    <= timeout_next;
      bit_cnt_reg    <= bit_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      match_cnt_reg  <= match_cnt_next;
      ovf_reg        <= ovf_next;
      abort_pend_reg <= abort_pend_next;
      code_reg       <= code_next;
      pos_reg        <= pos_next;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign match_cnt     = match_cnt_reg;
  assign evt_ovf       = ovf_reg;
  assign evt.evt_valid = (state_reg == REPORT);
  assign evt.evt_code  = code_reg;
  assign evt.evt_pos   = pos_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed bit streams, expected events queued
// by stimulus and checked by a monitor at each event handshake.
module tb_seq_detect_ctrl;

  localparam int LEN   = 9;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             data;
  logic             data_vld;
  logic [LEN-1:0]   cfg_pattern;
  logic [LEN-1:0]   cfg_mask;
  logic             cfg_oneshot;
  logic [TMO_W-1:0] cfg_timeout;
  logic             start;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] match_cnt;
  logic             evt_ovf;

  seq_detect_ctrl_if #(.TMO_W(TMO_W)) evt_if ();

  seq_detect_ctrl #(.LEN(LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .data_vld    (data_vld),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_oneshot (cfg_oneshot),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .match_cnt   (match_cnt),
    .evt_ovf     (evt_ovf),
    .evt         (evt_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    logic [15:0] pos;
    logic [7:0]  mcnt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] code, input logic [15:0] pos,
                          input logic [7:0] mcnt, input logic ovf);
    exp_t e;
    e.code = code; e.pos = pos; e.mcnt = mcnt; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: an event is consumed on the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event code=%0d pos=%0d required no event",
                 evt_if.evt_code, evt_if.evt_pos);
      end else begin
        mon_e = exp_q.pop_front();
        $display("EVT code=%0d pos=%0d match_cnt=%0d ovf=%0d",
                 evt_if.evt_code, evt_if.evt_pos, match_cnt, evt_ovf);
        chk("evt_code", 32'(evt_if.evt_code), 32'(mon_e.code));
        chk("evt_pos", 32'(evt_if.evt_pos), 32'(mon_e.pos));
        chk("evt_match_cnt", 32'(match_cnt), 32'(mon_e.mcnt));
        chk("evt_ovf", 32'(evt_ovf), 32'(mon_e.ovf));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [LEN-1:0] pat, input logic [LEN-1:0] msk,
                     input logic oneshot, input logic [TMO_W-1:0] tmo);
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_oneshot = oneshot;
    cfg_timeout = tmo;
    start       = 1'b1;
    tick;
    start       = 1'b0;
  endtask

  // Oldest bit is bits[n-1]; optional idle cycle between bits.
  task automatic send_bits(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      data     = bits[i];
      data_vld = 1'b1;
      tick;
      if (gaps && i > 0) begin
        data_vld = 1'b0;
        data     = ~data;
        tick;
      end
    end
    data_vld = 1'b0;
  endtask

  task automatic pulse_abort;
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam logic [LEN-1:0] PAT = 9'b011000110;
  localparam logic [LEN-1:0] MSK = 9'b111000111;

  initial begin
    rst_n = 1'b0; data = 1'b0; data_vld = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_oneshot = 1'b0; cfg_timeout = '0;
    evt_if.evt_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(evt_if.evt_valid), 0);
    chk("reset_code", 32'(evt_if.evt_code), 0);
    chk("reset_pos", 32'(evt_if.evt_pos), 0);
    chk("reset_match_cnt", 32'(match_cnt), 0);
    chk("reset_ovf", 32'(evt_ovf), 0);

    // Case 1: oneshot match, latency and return to IDLE
    arm(PAT, MSK, 1'b1, '0);
    chk("c1_busy", 32'(busy), 1);
    send_bits(32'b01110111, 8, 1'b0);
    chk("c1_valid_before", 32'(evt_if.evt_valid), 0);
    send_bits(32'b0, 1, 1'b0);
    chk("c1_valid_latency", 32'(evt_if.evt_valid), 1);
    push_exp(2'b01, 16'd9, 8'd1, 1'b0);
    evt_if.evt_ready = 1'b1;
    wait_drain("c1");
    chk("c1_idle", 32'(busy), 0);

    // Case 2: continuous, overlapping matches at 9 and 12, then abort in HUNT
    push_exp(2'b01, 16'd9, 8'd1, 1'b0);
    push_exp(2'b01, 16'd12, 8'd2, 1'b0);
    arm(PAT, MSK, 1'b0, '0);
    send_bits(32'b011011110110, 12, 1'b0);
    wait_drain("c2");
    chk("c2_busy_stays", 32'(busy), 1);
    push_exp(2'b11, 16'd12, 8'd2, 1'b0);
    pulse_abort;
    wait_drain("c2_abort");
    chk("c2_idle", 32'(busy), 0);

    // Case 3: timeout at bit 20, then match landing on bit 20 wins
    push_exp(2'b10, 16'd20, 8'd0, 1'b0);
    arm(PAT, MSK, 1'b1, 16'd20);
    send_bits(32'b0, 20, 1'b0);
    wait_drain("c3_tmo");
    chk("c3_tmo_idle", 32'(busy), 0);
    push_exp(2'b01, 16'd20, 8'd1, 1'b0);
    arm(PAT, MSK, 1'b1, 16'd20);
    send_bits(32'b00000000000011000110, 20, 1'b0);
    wait_drain("c3_match");
    chk("c3_match_idle", 32'(busy), 0);

    // Case 4: no ready through two matches, abort in REPORT, restart clears
    evt_if.evt_ready = 1'b0;
    arm(PAT, MSK, 1'b0, '0);
    send_bits(32'b011011110110, 12, 1'b0);
    chk("c4_match_cnt", 32'(match_cnt), 2);
    chk("c4_ovf", 32'(evt_ovf), 1);
    chk("c4_pos_held", 32'(evt_if.evt_pos), 9);
    pulse_abort;
    chk("c4_still_pending", 32'(evt_if.evt_valid), 1);
    push_exp(2'b01, 16'd9, 8'd2, 1'b1);
    evt_if.evt_ready = 1'b1;
    wait_drain("c4");
    chk("c4_idle", 32'(busy), 0);
    chk("c4_cnt_hold", 32'(match_cnt), 2);
    arm(PAT, MSK, 1'b0, '0);
    chk("c4_restart_cnt", 32'(match_cnt), 0);
    chk("c4_restart_ovf", 32'(evt_ovf), 0);
    push_exp(2'b11, 16'd0, 8'd0, 1'b0);
    pulse_abort;
    wait_drain("c4_abort");

    // Case 5: reset mid-FILL
    arm(PAT, MSK, 1'b1, '0);
    send_bits(32'b011, 3, 1'b0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("c5_busy", 32'(busy), 0);
    chk("c5_valid", 32'(evt_if.evt_valid), 0);
    chk("c5_pos", 32'(evt_if.evt_pos), 0);
    chk("c5_code", 32'(evt_if.evt_code), 0);

    // Case 6: gaps, start held, cfg changed while busy
    evt_if.evt_ready = 1'b0;
    cfg_pattern = PAT; cfg_mask = MSK; cfg_oneshot = 1'b1; cfg_timeout = '0;
    start = 1'b1;
    tick;
    cfg_pattern = '0; cfg_mask = '1; cfg_oneshot = 1'b0; cfg_timeout = 16'd3;
    send_bits(32'b011101110, 9, 1'b1);
    start = 1'b0;
    chk("c6_valid", 32'(evt_if.evt_valid), 1);
    push_exp(2'b01, 16'd9, 8'd1, 1'b0);
    evt_if.evt_ready = 1'b1;
    wait_drain("c6");
    chk("c6_idle", 32'(busy), 0);

    tick;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
